// File: rtl/mini_core_i_mem_rsp.sv
// Instruction-memory responder: accepts a fetch PC in Q100H and returns the word in Q101H.
// Define MINI_CORE_I_MEM_BACKDOOR_EN to add the loader/debug backdoor write port.
module mini_core_i_mem_rsp #(
  parameter int unsigned I_MEM_DEPTH  = 1024,
  parameter logic [31:0] I_MEM_OFFSET = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic [31:0] PcQ100H,
  input  logic        ReqValidQ100H,
  input  logic        ReadyQ101H,
  input  logic        FlushQ101H,
`ifdef MINI_CORE_I_MEM_BACKDOOR_EN
  input  logic        BdWrEnQnnnH,
  input  logic [31:0] BdWrAdrsQnnnH,
  input  logic [31:0] BdWrDataQnnnH,
`endif
  output logic        ReadyQ100H,
  output logic [31:0] InstructionQ101H,
  output logic        InstValidQ101H,
  output logic        AdrsErrQ101H,
  output logic        DbgStateQ101H
);

  // Handshake: a request transfers on a rising edge where ReqValidQ100H & ReadyQ100H;
  // a response transfers where InstValidQ101H & ReadyQ101H, and is held otherwise
  // unless FlushQ101H kills it.

  localparam int          AW      = (I_MEM_DEPTH > 1) ? $clog2(I_MEM_DEPTH) : 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] DEPTH_W = 32'(I_MEM_DEPTH);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_VALID = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [31:0] mem [I_MEM_DEPTH];

  logic [32:0]   rd_diff;
  logic [29:0]   rd_word;
  logic [AW-1:0] rd_idx;
  logic          rd_err;
  logic          accept;
  logic          unused_rd;

  logic          bd_we;
  logic [AW-1:0] bd_idx;
  logic [31:0]   bd_data;

  // The borrow bit of the 33-bit subtraction flags a PC below the array base.
  assign rd_diff   = {1'b0, PcQ100H} - {1'b0, I_MEM_OFFSET};
  assign rd_word   = rd_diff[31:2];
  assign rd_idx    = rd_word[AW-1:0];
  assign rd_err    = (PcQ100H[1:0] != 2'b00) | rd_diff[32] | ({2'b00, rd_word} >= DEPTH_W);
  assign unused_rd = ^rd_diff[1:0];

`ifdef MINI_CORE_I_MEM_BACKDOOR_EN
  logic [32:0] bd_diff;
  logic [29:0] bd_word;
  logic        unused_bd;

  assign bd_diff   = {1'b0, BdWrAdrsQnnnH} - {1'b0, I_MEM_OFFSET};
  assign bd_word   = bd_diff[31:2];
  assign bd_we     = BdWrEnQnnnH & ~bd_diff[32] & ({2'b00, bd_word} < DEPTH_W);
  assign bd_idx    = bd_word[AW-1:0];
  assign bd_data   = BdWrDataQnnnH;
  assign unused_bd = ^bd_diff[1:0];
  // A backdoor write owns the array for its cycle, so fetch is stalled.
  assign ReadyQ100H = ReadyQ101H & ~BdWrEnQnnnH;
`else
  assign bd_we      = 1'b0;
  assign bd_idx     = '0;
  assign bd_data    = '0;
  assign ReadyQ100H = ReadyQ101H;
`endif

  assign accept = ReqValidQ100H & ReadyQ100H;

  always_ff @(posedge Clock) begin
    if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      InstructionQ101H <= NOP;
      AdrsErrQ101H     <= 1'b0;
    end else if (accept) begin
      InstructionQ101H <= rd_err ? NOP : mem[rd_idx];
      AdrsErrQ101H     <= rd_err;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A new accept always wins over a flush of the current response.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = S_VALID;
    end else if (state_q == S_VALID && (FlushQ101H || ReadyQ101H)) begin
      state_d = S_EMPTY;
    end
  end

  assign InstValidQ101H = (state_q == S_VALID);
  assign DbgStateQ101H  = state_q;

endmodule

// File: tb/tb_mini_core_i_mem_rsp.sv
// Directed bench for mini_core_i_mem_rsp with a cycle-level behavioural model and scoreboard.
// Backdoor vectors run only when MINI_CORE_I_MEM_BACKDOOR_EN is defined.
module tb_mini_core_i_mem_rsp;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] OFF   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // clock / reset
  logic Clock = 1'b0;
  logic Rst   = 1'b0;
  always #5 Clock = ~Clock;

  logic [31:0] PcQ100H       = '0;
  logic        ReqValidQ100H = 1'b0;
  logic        ReadyQ101H    = 1'b1;
  logic        FlushQ101H    = 1'b0;
  logic        bd_en         = 1'b0;
  logic [31:0] bd_adrs       = '0;
  logic [31:0] bd_data       = '0;

  logic        ReadyQ100H;
  logic [31:0] InstructionQ101H;
  logic        InstValidQ101H;
  logic        AdrsErrQ101H;
  logic        DbgStateQ101H;

  mini_core_i_mem_rsp #(
    .I_MEM_DEPTH (DEPTH),
    .I_MEM_OFFSET(OFF)
  ) dut (
    .Clock           (Clock),
    .Rst             (Rst),
    .PcQ100H         (PcQ100H),
    .ReqValidQ100H   (ReqValidQ100H),
    .ReadyQ101H      (ReadyQ101H),
    .FlushQ101H      (FlushQ101H),
`ifdef MINI_CORE_I_MEM_BACKDOOR_EN
    .BdWrEnQnnnH     (bd_en),
    .BdWrAdrsQnnnH   (bd_adrs),
    .BdWrDataQnnnH   (bd_data),
`endif
    .ReadyQ100H      (ReadyQ100H),
    .InstructionQ101H(InstructionQ101H),
    .InstValidQ101H  (InstValidQ101H),
    .AdrsErrQ101H    (AdrsErrQ101H),
    .DbgStateQ101H   (DbgStateQ101H)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: response slot described by valid/instruction/error
  logic [31:0] model_mem [int];
  bit          m_valid = 1'b0;
  logic [31:0] m_instr = NOP;
  bit          m_err   = 1'b0;
  bit          m_known = 1'b1;
  longint unsigned mp, mb;
  bit          m_acc, m_e;

  always @(posedge Clock) begin
    mp    = longint'(PcQ100H);
    mb    = longint'(bd_adrs);
    m_acc = ReqValidQ100H && ReadyQ101H && !bd_en;
    if (!Rst) begin
      m_valid = 1'b0;
      m_instr = NOP;
      m_err   = 1'b0;
      m_known = 1'b1;
    end else if (m_acc) begin
      m_e     = (mp % 4 != 0) || (mp < OFF) || ((mp - OFF) / 4 >= DEPTH);
      m_err   = m_e;
      m_valid = 1'b1;
      if (m_e) begin
        m_instr = NOP;
        m_known = 1'b1;
      end else if (model_mem.exists(int'((mp - OFF) / 4))) begin
        m_instr = model_mem[int'((mp - OFF) / 4)];
        m_known = 1'b1;
      end else begin
        m_known = 1'b0;
      end
    end else if (m_valid && (FlushQ101H || ReadyQ101H)) begin
      m_valid = 1'b0;
    end
    if (bd_en && mb >= OFF && (mb - OFF) / 4 < DEPTH) begin
      model_mem[int'((mb - OFF) / 4)] = bd_data;
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge Clock) begin
    chk("valid", {31'b0, InstValidQ101H}, {31'b0, m_valid});
    chk("dbg_state", {31'b0, DbgStateQ101H}, {31'b0, m_valid});
    chk("adrs_err", {31'b0, AdrsErrQ101H}, {31'b0, m_err});
    chk("ready100", {31'b0, ReadyQ100H}, {31'b0, ReadyQ101H & ~bd_en});
    if (m_known) chk("instruction", InstructionQ101H, m_instr);
  end

  task automatic step();
    @(negedge Clock);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    dut.mem[idx]   = d;
    model_mem[idx] = d;
  endtask

  task automatic req(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    ReqValidQ100H = v;
    PcQ100H       = pc;
    ReadyQ101H    = rdy;
    FlushQ101H    = fl;
  endtask

  initial begin
    preload(64, 32'hAAAA_0001);
    preload(65, 32'hAAAA_0002);
    preload(0, 32'h1111_0000);
    preload(1023, 32'h2222_03FF);

    req(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    step();
    chk("lit_reset_valid", {31'b0, InstValidQ101H}, 32'd0);
    chk("lit_reset_instr", InstructionQ101H, NOP);
    Rst = 1'b1;
    step();

    // back-to-back fetch
    req(1'b1, 32'h100, 1'b1, 1'b0);
    step();
    chk("lit_b2b_0", InstructionQ101H, 32'hAAAA_0001);
    req(1'b1, 32'h104, 1'b1, 1'b0);
    step();
    chk("lit_b2b_1", InstructionQ101H, 32'hAAAA_0002);
    chk("lit_b2b_valid", {31'b0, InstValidQ101H}, 32'd1);
    req(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk("lit_consumed", {31'b0, InstValidQ101H}, 32'd0);

    // stall hold with a request pending
    req(1'b1, 32'h100, 1'b1, 1'b0);
    step();
    req(1'b1, 32'h104, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("lit_stall_ready", {31'b0, ReadyQ100H}, 32'd0);
      step();
      chk("lit_stall_instr", InstructionQ101H, 32'hAAAA_0001);
    end
    req(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk("lit_release_empty", {31'b0, InstValidQ101H}, 32'd0);

    // flush without and with a request
    req(1'b1, 32'h100, 1'b1, 1'b0);
    step();
    req(1'b0, 32'h0, 1'b0, 1'b1);
    step();
    chk("lit_flush_kill", {31'b0, InstValidQ101H}, 32'd0);
    req(1'b1, 32'h100, 1'b1, 1'b0);
    step();
    req(1'b1, 32'h104, 1'b1, 1'b1);
    step();
    chk("lit_flush_req", InstructionQ101H, 32'hAAAA_0002);
    chk("lit_flush_req_valid", {31'b0, InstValidQ101H}, 32'd1);

    // address errors and range boundaries
    req(1'b1, 32'h102, 1'b1, 1'b0);
    step();
    chk("lit_misaligned", {31'b0, AdrsErrQ101H}, 32'd1);
    chk("lit_misaligned_nop", InstructionQ101H, NOP);
    req(1'b1, 32'(4 * DEPTH), 1'b1, 1'b0);
    step();
    chk("lit_oob", {31'b0, AdrsErrQ101H}, 32'd1);
    req(1'b1, 32'(4 * DEPTH - 4), 1'b1, 1'b0);
    step();
    chk("lit_last_word", InstructionQ101H, 32'h2222_03FF);
    chk("lit_last_err", {31'b0, AdrsErrQ101H}, 32'd0);
    req(1'b1, 32'h0, 1'b1, 1'b0);
    step();
    chk("lit_first_word", InstructionQ101H, 32'h1111_0000);
    req(1'b0, 32'h0, 1'b1, 1'b0);
    step();

`ifdef MINI_CORE_I_MEM_BACKDOOR_EN
    req(1'b1, 32'h200, 1'b1, 1'b0);
    bd_en   = 1'b1;
    bd_adrs = 32'h200;
    bd_data = 32'hDEAD_BEEF;
    chk("lit_bd_stall", {31'b0, ReadyQ100H}, 32'd0);
    step();
    bd_en = 1'b0;
    step();
    chk("lit_bd_read", InstructionQ101H, 32'hDEAD_BEEF);
    req(1'b0, 32'h0, 1'b1, 1'b0);
    bd_en   = 1'b1;
    bd_adrs = 32'(4 * DEPTH);
    bd_data = 32'h1234_5678;
    step();
    bd_en = 1'b0;
    req(1'b1, 32'h0, 1'b1, 1'b0);
    step();
    chk("lit_bd_oob_dropped", InstructionQ101H, 32'h1111_0000);
    req(1'b0, 32'h0, 1'b1, 1'b0);
    step();
`endif

    // reset while holding a stalled response
    req(1'b1, 32'h104, 1'b1, 1'b0);
    step();
    req(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk("lit_held_before_rst", InstructionQ101H, 32'hAAAA_0002);
    Rst = 1'b0;
    step();
    chk("lit_rst_valid", {31'b0, InstValidQ101H}, 32'd0);
    chk("lit_rst_instr", InstructionQ101H, NOP);
    Rst = 1'b1;
    req(1'b0, 32'h0, 1'b1, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mini_core_i_mem_rsp.md
# mini_core_i_mem_rsp

Instruction-memory responder for the mini_core fetch stage. It accepts the fetch PC issued in Q100H, reads a word-addressed instruction array, and returns the instruction in Q101H. It drives the fetch-stage `ReadyQ100H` backpressure, holds its response while decode stalls, and drops in-flight responses on a branch/jump redirect. An optional backdoor write port lets the loader or debug logic fill the array.

## Interface
Parameters:
- `I_MEM_DEPTH`, 1024 — number of 32-bit instruction words; power of two.
- `I_MEM_OFFSET`, 32'h0000_0000 — byte address of word 0; word-aligned.

Ports:
- `Clock`  in  1  — single clock; all state is updated on the rising edge.
- `Rst`  in  1  — synchronous, active-low reset; state resets on a rising edge with `Rst`=0.
- `PcQ100H`  in  32  — fetch byte address.
- `ReqValidQ100H`  in  1  — fetch request present this cycle.
- `ReadyQ101H`  in  1  — decode accepts the current Q101H response.
- `FlushQ101H`  in  1  — redirect (SelNextPcAluOutQ102H); kills the Q101H response.
- `ReadyQ100H`  out  1  — responder accepts a request this cycle.
- `InstructionQ101H`  out  32  — returned instruction.
- `InstValidQ101H`  out  1  — `InstructionQ101H` is valid.
- `AdrsErrQ101H`  out  1  — returned response came from a misaligned or out-of-range PC.
- `BdWrEnQnnnH`  in  1  — backdoor write strobe (only with the macro).
- `BdWrAdrsQnnnH`  in  32  — backdoor byte address (only with the macro).
- `BdWrDataQnnnH`  in  32  — backdoor write data (only with the macro).

## Operation
- Word index = (`PcQ100H` − `I_MEM_OFFSET`) >> 2, truncated to log2(`I_MEM_DEPTH`) bits.
- Accept = `ReqValidQ100H` & `ReadyQ100H`. `ReadyQ100H` = `ReadyQ101H` & !`BdWrEnQnnnH`. This is combinational, with no state dependence.
- On accept:
  - The array read register loads the word.
  - `AdrsErrQ101H` loads (`PcQ100H[1:0]`≠0) | (`PcQ100H` < `I_MEM_OFFSET`) | (index ≥ `I_MEM_DEPTH`, computed untruncated).
  - On error, `InstructionQ101H` is 32'h0000_0013 (NOP) instead of array data.
- FSM, two states:
  - EMPTY → VALID on accept, regardless of `FlushQ101H`.
  - VALID → VALID on accept.
  - VALID → EMPTY on no accept with `FlushQ101H`=1, or on no accept with `ReadyQ101H`=1 (response consumed).
  - VALID → VALID (hold) on no accept with `ReadyQ101H`=0 and `FlushQ101H`=0.
  - EMPTY stays EMPTY with no accept.
- `InstValidQ101H` = (state==VALID).
- While held, `InstructionQ101H` and `AdrsErrQ101H` are stable; the read register is not re-enabled.
- A flush in the same cycle as an accept: the newly accepted request wins and is valid next cycle (the flush kills only the current response).
- The array is not reset. Reads return X until written.

## Timing
- Latency: accept at cycle N → response valid at N+1. Throughput is 1 per cycle while `ReadyQ101H`=1.
- Reset values: `InstructionQ101H`=32'h0000_0013, `InstValidQ101H`=0, `AdrsErrQ101H`=0, state=EMPTY.
- `ReadyQ100H` is 0 during reset cycles only because of its inputs. The bench keeps `ReqValidQ100H`=0 while `Rst`=0.
- Reset mid-operation: the response is discarded and outputs return to their reset values the next cycle.
- Backdoor write at cycle N is visible to a read accepted at N+1 or later. There is no same-cycle read/write because writes force `ReadyQ100H`=0.
- Out-of-range backdoor writes are dropped silently.

## Configuration
- `MINI_CORE_I_MEM_BACKDOOR_EN` defined:
  - Backdoor ports are present.
  - A write stores `BdWrDataQnnnH` at word (`BdWrAdrsQnnnH`−`I_MEM_OFFSET`)>>2 and stalls fetch that cycle.
- Undefined:
  - Backdoor ports are absent.
  - `ReadyQ100H` = `ReadyQ101H`.
  - The array is loaded only by the bench via hierarchical preload.

## Test plan
- Back-to-back fetch: after preload of 0x100→32'hAAAA_0001 and 0x104→32'hAAAA_0002, issue `PcQ100H`=0x100 then 0x104 with ready=1 → outputs 32'hAAAA_0001 then 32'hAAAA_0002 in consecutive cycles, valid=1.
- Stall hold: `ReadyQ101H`=0 for 3 cycles after a fetch of 0x100 → `InstructionQ101H` stays 32'hAAAA_0001, valid=1, and `ReadyQ100H`=0. Release → one-cycle consume, then EMPTY if no request is pending.
- Flush: `FlushQ101H`=1 with no request → valid=0 next cycle. Flush together with a request to 0x104 → 32'hAAAA_0002 valid next cycle.
- Address error: `PcQ100H`=0x102, then 4*`I_MEM_DEPTH` → `AdrsErrQ101H`=1, `InstructionQ101H`=32'h0000_0013, valid=1.
- Backdoor (macro on): write 0x200←32'hDEAD_BEEF at N with a request pending → `ReadyQ100H`=0 at N. A fetch of 0x200 accepted at N+1 returns 32'hDEAD_BEEF at N+2.
- Mid-stream reset: `Rst`=0 for one cycle while VALID and stalled → `InstValidQ101H`=0 and instruction = 32'h0000_0013 the next cycle.
